// File: rtl/vic_pkg.sv
// Shared types and constants for the vectored interrupt controller front end.
package vic_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
   localparam logic [31:0] VEC_STRIDE_DEF = 32'd4;

   function automatic int IRQ_ID_W(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vic_prio_enc.sv
// Lowest-index-first priority encoder over the enabled pending sources.
module vic_prio_enc #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] cand,
   output logic         valid,
   output logic [W-1:0] id
);

   // Scanning from the top lets the lowest set index overwrite last.
   always_comb begin
      valid = 1'b0;
      id    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (cand[i]) begin
            valid = 1'b1;
            id    = W'(i);
         end
      end
   end

endmodule

// File: rtl/vic_irq_arbiter.sv
// Interrupt front end: edge capture, pending/mask registers and a
// non-preemptive request/service handshake toward the VIC control stage.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | no request; pick the winning enabled pending source
//   REQ     | o_IRQ high, grant frozen, waiting for i_ack
//   SERVICE | ISR running, o_IRQ held high until i_reti
module vic_irq_arbiter
   import vic_pkg::*;
#(
   parameter int          N_IRQ      = 8,
   parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
   parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF,
   localparam int         ID_W       = IRQ_ID_W(N_IRQ)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [N_IRQ-1:0]  i_irq_lines,
   input  logic              i_mask_we,
   input  logic [N_IRQ-1:0]  i_mask_wdata,
   input  logic              i_ack,
   input  logic              i_reti,
   output logic              o_IRQ,
   output logic [31:0]       o_ISR_addr,
   output logic [ID_W-1:0]   o_irq_id,
   output logic              o_busy,
   output logic [N_IRQ-1:0]  o_pending,
   output logic [N_IRQ-1:0]  o_mask
);

   state_t             state_q, state_d;
   logic [N_IRQ-1:0]   hist_q, pending_q, mask_q;
   logic [N_IRQ-1:0]   rise, cand, clr;
   logic               enc_valid, load, take_ack;
   logic [ID_W-1:0]    enc_id, id_q;
   logic [31:0]        addr_q;

   assign rise = i_irq_lines & ~hist_q;
   assign cand = pending_q & mask_q;

   vic_prio_enc #(
      .N (N_IRQ),
      .W (ID_W)
   ) u_prio_enc (
      .cand  (cand),
      .valid (enc_valid),
      .id    (enc_id)
   );

   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      take_ack = 1'b0;
      case (state_q)
         IDLE: begin
            if (enc_valid) begin
               load    = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (i_ack) begin
               take_ack = 1'b1;
               state_d  = SERVICE;
            end
         end
         SERVICE: begin
            if (i_reti) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      clr = '0;
      if (take_ack) clr[id_q] = 1'b1;
   end

   // History resets to ones so lines already high at reset release stay quiet.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         hist_q    <= '1;
         pending_q <= '0;
         mask_q    <= '0;
         id_q      <= '0;
         addr_q    <= '0;
      end else begin
         state_q   <= state_d;
         hist_q    <= i_irq_lines;
         pending_q <= (pending_q & ~clr) | rise;
         if (i_mask_we) mask_q <= i_mask_wdata;
         if (load) begin
            id_q   <= enc_id;
            addr_q <= VEC_BASE + {{(32 - ID_W){1'b0}}, enc_id} * VEC_STRIDE;
         end
      end
   end

   assign o_IRQ      = (state_q != IDLE);
   assign o_busy     = (state_q != IDLE);
   assign o_ISR_addr = addr_q;
   assign o_irq_id   = id_q;
   assign o_pending  = pending_q;
   assign o_mask     = mask_q;

endmodule

// File: doc/vic_irq_arbiter.md
Name: vic_irq_arbiter

Overview:
- Front end of the vectored interrupt controller.
- Latches rising edges on N external interrupt lines into a pending register and applies a software-writable enable mask.
- Picks the highest-priority enabled pending source, lowest index first.
- Presents one request at a time to the VIC control stage as a clean level-then-drop `o_IRQ` plus the ISR vector address.
- Non-preemptive: no new request is raised until the running ISR signals return.

Parameters:
- `N_IRQ`, 8, number of interrupt sources; legal range 2..32.
- `VEC_BASE`, 32'h0000_0100, byte address of vector table entry 0.
- `VEC_STRIDE`, 4, byte distance between consecutive vector entries.

Ports:
- `i_clk`  in  1  system clock; all state updates on its rising edge.
- `i_rst`  in  1  synchronous reset, active-high.
- `i_irq_lines`  in  N_IRQ  interrupt sources, synchronous to `i_clk`, edge-triggered.
- `i_mask_we`  in  1  write strobe for the enable mask.
- `i_mask_wdata`  in  N_IRQ  new enable mask; 1 = source enabled.
- `i_ack`  in  1  core has taken the vector (PC redirected, not stalled).
- `i_reti`  in  1  return-from-interrupt executed; one-cycle pulse.
- `o_IRQ`  out  1  request to the VIC control stage.
- `o_ISR_addr`  out  32  vector address of the granted source.
- `o_irq_id`  out  clog2(N_IRQ)  index of the granted source.
- `o_busy`  out  1  high while a request is outstanding or an ISR is running.
- `o_pending`  out  N_IRQ  pending register, readable.
- `o_mask`  out  N_IRQ  current enable mask.

Behaviour:
- Reset values: `o_IRQ`=0, `o_ISR_addr`=0, `o_irq_id`=0, `o_busy`=0, pending=0, mask=0, state=IDLE.
- Edge-detect history register resets to all ones, so lines already high at reset release raise no interrupt.
- Edge detect: `pending[i]` sets on the cycle after `i_irq_lines[i]` is sampled 0 then 1.
- A level held high does not re-trigger.
- Mask: on `i_mask_we`, mask <= `i_mask_wdata`; it takes effect from the next cycle.
- Masking never clears pending bits. A masked pending bit fires once it is unmasked.
- Candidate = pending & mask; the winner is the lowest set index.
- Vector: `o_ISR_addr` = `VEC_BASE` + id*`VEC_STRIDE`, computed in 32-bit unsigned arithmetic with wrap-around permitted.
- FSM states:
  - IDLE: `o_IRQ`=0, `o_busy`=0. If candidate != 0, register the winner id and vector, go to REQ.
  - REQ: `o_IRQ`=1, `o_busy`=1. Holds until `i_ack`. On `i_ack`, clear `pending[id]` and go to SERVICE. The grant is committed: a mask change or a higher-priority arrival does not retarget it.
  - SERVICE: `o_IRQ`=1, `o_busy`=1. Holds until `i_reti`, then go to IDLE with `o_IRQ`=0.
- `o_IRQ` drops for at least one cycle between consecutive services. This guarantees a fresh rising edge for the downstream stage.
- Latency: a line rises at sampled edge k, pending is visible after edge k, and `o_IRQ`/`o_ISR_addr` are valid after edge k+1.
- A back-to-back pending source is re-requested 2 cycles after `i_reti`: IDLE for 1 cycle, then REQ.
- Simultaneous events:
  - A new edge on a source whose bit is being cleared by `i_ack` in the same cycle: the set wins and the bit stays pending.
  - `i_ack` outside REQ is ignored.
  - `i_reti` outside SERVICE is ignored.
  - `i_ack` and `i_reti` together in REQ: only the ack is taken, and the FSM goes to SERVICE.
- Reset asserted mid-operation: all state returns to reset values on that edge, and in-flight grants are dropped.
- `o_irq_id`, `o_ISR_addr`: stable from entry into REQ until the next IDLE→REQ transition.

Decomposition:
- Package `vic_pkg` holds:
  - the state enum (IDLE, REQ, SERVICE);
  - the default `VEC_BASE`/`VEC_STRIDE` constants;
  - an `IRQ_ID_W` function computing clog2(N_IRQ).
- Sub-module `vic_prio_enc`: combinational lowest-index finder. Inputs: N_IRQ candidate vector. Outputs: valid and id.
- Edge detect, pending/mask registers and the FSM stay in the top module.

Test Plan:
- Reset released with `i_irq_lines`=8'h04 held high → no pending, `o_IRQ`=0. Then drop and re-raise line 2 → `o_IRQ`=1 after 2 cycles, `o_ISR_addr`=32'h108, `o_irq_id`=2.
- Mask=8'hFF, lines 5 and 1 rise in the same cycle → grant id 1 (addr 32'h104). After `i_ack` and `i_reti`, `o_IRQ` is low for 1 cycle, then grant id 5 (addr 32'h114).
- Mask=8'h00, line 3 rises → `o_pending`=8'h08, `o_IRQ` stays 0. Write mask=8'h08 → `o_IRQ`=1 two cycles after the write with id 3.
- In REQ for id 4: write mask=0 and raise line 0 → id 4 stays granted until `i_ack`. Line 0 is pending but not requested while the mask is 0.
- Line 6 re-rises in the same cycle as `i_ack` for id 6 → `pending[6]` stays 1, and the grant repeats after `i_reti`.
- Assert `i_rst` in SERVICE → next cycle `o_IRQ`=0, `o_busy`=0, pending=0, mask=0. A following spurious `i_reti` is ignored.
